// File: rtl/myproject_mul_rr_sched.sv
// Round-robin scheduler sharing one unsigned multiplier among NUM_REQ requesters.
// The result register doubles as a one-deep output slot with a valid/ready handshake.
module myproject_mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 5,
    parameter int B_W     = 10,
    parameter int P_W     = 14
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_ovf,
    output logic [15:0]            op_count
);

    localparam int FULL_W = A_W + B_W;

    logic                r_rsp_valid;
    logic [P_W-1:0]      r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_ovf;
    logic [15:0]         r_op_count;
    logic [ID_W-1:0]     r_rr_ptr;

    logic                w_slot_free;
    logic                w_found;
    logic [ID_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_xfer;
    logic [A_W-1:0]      w_a;
    logic [B_W-1:0]      w_b;
    logic [FULL_W-1:0]   w_prod;
    logic                w_ovf;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Distance from rr_ptr+1 (mod NUM_REQ) ranks requesters; the smallest distance wins.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        w_found     = 1'b0;
        w_grant_idx = '0;
        best_d      = NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - int'(r_rr_ptr) - 1) % NUM_REQ;
            if (req_valid[i] && (d < best_d)) begin
                best_d      = d;
                w_grant_idx = ID_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_found && (w_grant_idx == ID_W'(i)) && w_slot_free && !ap_rst;
        end
    end

    assign w_xfer    = |w_ready;
    assign req_ready = w_ready;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_a = req_a[i*A_W +: A_W];
                w_b = req_b[i*B_W +: B_W];
            end
        end
    end

    assign w_prod = FULL_W'(w_a) * FULL_W'(w_b);

    generate
        if (P_W < FULL_W) begin : g_ovf
            assign w_ovf = |w_prod[FULL_W-1:P_W];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_ovf   <= 1'b0;
            r_op_count  <= '0;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= P_W'(w_prod);
            r_rsp_id    <= w_grant_idx;
            r_rsp_ovf   <= w_ovf;
            r_op_count  <= r_op_count + 16'd1;
            r_rr_ptr    <= w_grant_idx;
        end else if (w_slot_free) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_ovf   = r_rsp_ovf;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_myproject_mul_rr_sched.sv
// Directed bench for myproject_mul_rr_sched: a vector table plus hand-written
// sequences for round-robin, stall, asynchronous reset and op_count wrap.
module tb_myproject_mul_rr_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_a = '0;
    logic [39:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [13:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;
    logic [15:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    myproject_mul_rr_sched #(
        .NUM_REQ(4), .ID_W(2), .A_W(5), .B_W(10), .P_W(14)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf), .op_count(op_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [4:0]  a;
        logic [9:0]  b;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_rvalid;
        logic [13:0] exp_data;
        logic [1:0]  exp_id;
        logic        exp_ovf;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [4:0] a, input logic [9:0] b, input logic rdy);
        req_valid = v;
        req_a     = {4{a}};
        req_b     = {4{b}};
        rsp_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        drive(4'b0000, 5'd0, 10'd0, 1'b0);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 5'd31, 10'd1023, 1'b1, 4'b0001, 1'b1, 14'd15329, 2'd0, 1'b1, 16'd1};
        vecs[1] = '{4'b0100, 5'd3,  10'd7,    1'b1, 4'b0100, 1'b1, 14'd21,    2'd2, 1'b0, 16'd2};
        vecs[2] = '{4'b1111, 5'd2,  10'd5,    1'b1, 4'b1000, 1'b1, 14'd10,    2'd3, 1'b0, 16'd3};
        vecs[3] = '{4'b1111, 5'd2,  10'd5,    1'b1, 4'b0001, 1'b1, 14'd10,    2'd0, 1'b0, 16'd4};
        vecs[4] = '{4'b1111, 5'd2,  10'd5,    1'b1, 4'b0010, 1'b1, 14'd10,    2'd1, 1'b0, 16'd5};
        vecs[5] = '{4'b0000, 5'd9,  10'd9,    1'b1, 4'b0000, 1'b0, 14'd10,    2'd1, 1'b0, 16'd5};
        vecs[6] = '{4'b0110, 5'd1,  10'd1,    1'b0, 4'b0100, 1'b1, 14'd1,     2'd2, 1'b0, 16'd6};
        vecs[7] = '{4'b0110, 5'd7,  10'd7,    1'b0, 4'b0000, 1'b1, 14'd1,     2'd2, 1'b0, 16'd6};
        vecs[8] = '{4'b0011, 5'd31, 10'd1023, 1'b1, 4'b0001, 1'b1, 14'd15329, 2'd0, 1'b1, 16'd7};

        // Reset state
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge ap_clk);
            drive(vecs[k].valid, vecs[k].a, vecs[k].b, vecs[k].rdy);
            #1;
            check($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
            @(posedge ap_clk);
            #1;
            check($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].exp_rvalid));
            check($sformatf("v%0d_rsp_data", k),  32'(rsp_data),  32'(vecs[k].exp_data));
            check($sformatf("v%0d_rsp_id", k),    32'(rsp_id),    32'(vecs[k].exp_id));
            check($sformatf("v%0d_rsp_ovf", k),   32'(rsp_ovf),   32'(vecs[k].exp_ovf));
            check($sformatf("v%0d_op_count", k),  32'(op_count),  32'(vecs[k].exp_count));
        end

        // Round-robin with all requesters valid: 0,1,2,3,0,1,2,3 at full rate
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            drive(4'b1111, 5'd4, 10'd3, 1'b1);
            #1;
            check($sformatf("rr%0d_req_ready", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
            @(posedge ap_clk);
            #1;
            check($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("rr%0d_rsp_id", i),    32'(rsp_id),    32'(i % 4));
        end
        check("rr_op_count", 32'(op_count), 32'd8);
        check("rr_rsp_data", 32'(rsp_data), 32'd12);

        // Stall: held result stays stable and no grant; operand changes ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            drive(4'b0110, 5'(i + 10), 10'(i + 100), 1'b0);
            #1;
            check($sformatf("st%0d_req_ready", i), 32'(req_ready), 32'd0);
            @(posedge ap_clk);
            #1;
            check($sformatf("st%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("st%0d_rsp_data", i),  32'(rsp_data),  32'd12);
            check($sformatf("st%0d_rsp_id", i),    32'(rsp_id),    32'd3);
            check($sformatf("st%0d_op_count", i),  32'(op_count),  32'd8);
        end
        @(negedge ap_clk);
        drive(4'b0110, 5'd3, 10'd7, 1'b1);
        #1;
        check("unstall_req_ready", 32'(req_ready), 32'(4'b0010));
        @(posedge ap_clk);
        #1;
        check("unstall_rsp_id",   32'(rsp_id),   32'd1);
        check("unstall_rsp_data", 32'(rsp_data), 32'd21);
        check("unstall_rsp_valid", 32'(rsp_valid), 32'd1);

        // Asynchronous reset mid-cycle discards the pending result
        @(negedge ap_clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        #2;
        ap_rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_op_count",  32'(op_count),  32'd0);
        check("arst_rsp_data",  32'(rsp_data),  32'd0);
        req_valid = 4'b1100;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        drive(4'b1100, 5'd5, 10'd5, 1'b1);
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'(4'b0100));
        @(posedge ap_clk);
        #1;
        check("post_rst_rsp_id", 32'(rsp_id), 32'd2);
        check("post_rst_rsp_data", 32'(rsp_data), 32'd25);

        // op_count wrap: 65537 transfers from reset
        do_reset();
        @(negedge ap_clk);
        drive(4'b0001, 5'd1, 10'd1, 1'b1);
        for (int i = 0; i < 65535; i++) @(posedge ap_clk);
        #1;
        check("wrap_count_ffff", 32'(op_count), 32'hFFFF);
        @(posedge ap_clk);
        #1;
        check("wrap_count_0", 32'(op_count), 32'd0);
        @(posedge ap_clk);
        #1;
        check("wrap_count_1", 32'(op_count), 32'd1);
        @(negedge ap_clk);
        drive(4'b0000, 5'd0, 10'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
